barrel_shift_l_pipe: RTL and testbench

Pipelined left barrel shifter that complements the existing combinational right barrel shifter. It supports both logical-left and rotate-left modes. Each of log2(WIDTH) register stages resolves one bit of the shift amount, so throughput is one word per clock. A valid/ready handshake on both sides lets it sit between streaming producers and consumers, and backpressure stalls the pipeline without losing or duplicating words.

---
 rtl/barrel_shift_l_pipe_pkg.sv | 17 +
 rtl/barrel_shift_l_pipe_if.sv | 29 ++
 rtl/barrel_shift_l_pipe_stage.sv | 50 +++++
 rtl/barrel_shift_l_pipe.sv | 73 +++++++
 tb/tb_barrel_shift_l_pipe.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/barrel_shift_l_pipe_pkg.sv
// Shared constants and stage record for the pipelined left barrel shifter.
package shift_pkg;

  localparam int SHIFT_W      = 32;
  localparam int SHIFT_AMNT_W = 5;

  localparam logic SHIFT_LOGICAL = 1'b0;
  localparam logic SHIFT_ROTATE  = 1'b1;

  typedef struct packed {
    logic                    valid;
    logic [SHIFT_W-1:0]      data;
    logic [SHIFT_AMNT_W-1:0] amnt;
    logic                    rot;
  } shift_stage_t;

endpackage

// File: rtl/barrel_shift_l_pipe_if.sv
// Streaming handshake bundle: producer-side word in, consumer-side result out.
interface barrel_shift_l_pipe_if
  import shift_pkg::*;
#(
  parameter int WIDTH  = SHIFT_W,
  parameter int AMNT_W = $clog2(WIDTH)
);

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  shift_str;
  logic [AMNT_W-1:0] shift_amnt;
  logic              rotate;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  shifted_str;

  // master drives words in and consumes results; slave is the shifter
  modport master (
    output in_valid, shift_str, shift_amnt, rotate, out_ready,
    input  in_ready, out_valid, shifted_str
  );

  modport slave (
    input  in_valid, shift_str, shift_amnt, rotate, out_ready,
    output in_ready, out_valid, shifted_str
  );

endinterface

// File: rtl/barrel_shift_l_pipe_stage.sv
// One registered shifter stage: conditionally shifts by a fixed 2^K and holds under stall.
module shift_l_stage
  import shift_pkg::*;
#(
  parameter int WIDTH  = SHIFT_W,
  parameter int AMNT_W = $clog2(WIDTH),
  parameter int K      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid,
  input  logic [WIDTH-1:0]  up_data,
  input  logic [AMNT_W-1:0] up_amnt,
  input  logic              up_rot,
  input  logic              dn_adv,
  output logic              valid,
  output logic [WIDTH-1:0]  data,
  output logic [AMNT_W-1:0] amnt,
  output logic              rot
);

  localparam int S = 2 ** K;

  logic [WIDTH-1:0] shl, wrap, nxt;
  logic             adv;

  assign shl  = up_data << S;
  assign wrap = up_data >> (WIDTH - S);
  assign nxt  = up_amnt[K] ? (shl | ((up_rot == SHIFT_ROTATE) ? wrap : '0)) : up_data;

  // empty slot or a downstream that will move both let this stage load
  assign adv = ~valid | dn_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      amnt  <= '0;
      rot   <= 1'b0;
    end else if (adv) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= nxt;
        amnt <= up_amnt;
        rot  <= up_rot;
      end
    end
  end

endmodule

// File: rtl/barrel_shift_l_pipe.sv
// Pipelined left barrel shifter (logical / rotate), one amount bit resolved per stage.
module barrel_shift_l_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = SHIFT_W,
  parameter int AMNT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  barrel_shift_l_pipe_if.slave  bus
);

  logic [AMNT_W-1:0]             vld_pipe;
  logic [AMNT_W-1:0][WIDTH-1:0]  data_pipe;
  logic [AMNT_W-1:0][AMNT_W-1:0] amnt_pipe;
  logic [AMNT_W-1:0]             rot_pipe;

  // Stage 0 can load unless every stage is full and the consumer is stalling;
  // no transfer is offered while reset is being applied.
  assign bus.in_ready    = (~(&vld_pipe) | bus.out_ready) & ~rst;
  assign bus.out_valid   = vld_pipe[AMNT_W-1];
  assign bus.shifted_str = data_pipe[AMNT_W-1];

  for (genvar k = 0; k < AMNT_W; k++) begin : g_stage
    logic              up_valid;
    logic [WIDTH-1:0]  up_data;
    logic [AMNT_W-1:0] up_amnt;
    logic              up_rot;
    logic              dn_adv;

    if (k == 0) begin : g_first
      assign up_valid = bus.in_valid;
      assign up_data  = bus.shift_str;
      assign up_amnt  = bus.shift_amnt;
      assign up_rot   = bus.rotate;
    end else begin : g_chain
      assign up_valid = vld_pipe[k-1];
      assign up_data  = data_pipe[k-1];
      assign up_amnt  = amnt_pipe[k-1];
      assign up_rot   = rot_pipe[k-1];
    end

    // closed form of the recursive advance chain: any bubble downstream frees a slot
    if (k == AMNT_W-1) begin : g_tail
      assign dn_adv = bus.out_ready;
    end else begin : g_body
      assign dn_adv = bus.out_ready | ~(&vld_pipe[AMNT_W-1:k+1]);
    end

    shift_l_stage #(
      .WIDTH  (WIDTH),
      .AMNT_W (AMNT_W),
      .K      (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_valid),
      .up_data  (up_data),
      .up_amnt  (up_amnt),
      .up_rot   (up_rot),
      .dn_adv   (dn_adv),
      .valid    (vld_pipe[k]),
      .data     (data_pipe[k]),
      .amnt     (amnt_pipe[k]),
      .rot      (rot_pipe[k])
    );
  end

  // amount and mode of the last stage travel for debug visibility only
  logic unused_tail;
  assign unused_tail = ^{amnt_pipe[AMNT_W-1], rot_pipe[AMNT_W-1]};

endmodule

// File: tb/tb_barrel_shift_l_pipe.sv
// Scoreboarded random + directed bench for barrel_shift_l_pipe.
module tb_barrel_shift_l_pipe;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  barrel_shift_l_pipe_if #(.WIDTH(SHIFT_W), .AMNT_W(SHIFT_AMNT_W)) bus ();

  barrel_shift_l_pipe #(.WIDTH(SHIFT_W), .AMNT_W(SHIFT_AMNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rr_mode = 1'b0;
  shift_stage_t exp_q[$];
  int out_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // reference: view the word as the top half of a 64-bit window and shift the window
  function automatic logic [31:0] ref_shift(logic [31:0] d, int a, logic r);
    logic [63:0] w;
    w = r ? {d, d} : {d, 32'h0};
    w = w << a;
    return w[63:32];
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: a transfer completes at the next rising edge when valid & ready here
  always @(negedge clk) begin : mon
    shift_stage_t e;
    #2;
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected no word", bus.shifted_str);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", bus.shifted_str, e.data);
        out_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) if (rr_mode) bus.out_ready = 1'($urandom_range(0, 1));

  task automatic send(logic [31:0] d, logic [4:0] a, logic r, logic [31:0] e);
    int n = 0;
    shift_stage_t s;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.shift_str = d; bus.shift_amnt = a; bus.rotate = r;
    #1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready %b expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    s = '{valid: 1'b1, data: e, amnt: a, rot: r};
    exp_q.push_back(s);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(logic [4:0] a, logic r);
    logic [31:0] d;
    d = $urandom;
    send(d, a, r, ref_shift(d, int'(a), r));
  endtask

  task automatic wait_latency(string name);
    int n = 0;
    do begin
      @(negedge clk); #2; n++;
    end while (bus.out_valid !== 1'b1 && n < 20);
    check(name, n, 5);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk); n++;
    end
    @(negedge clk); #3;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd[8];
    logic [4:0]  wa[8];
    logic        wr[8];
    logic [31:0] hold;
    int acc, base, ok;

    rst = 1'b1;
    bus.in_valid = 1'b0; bus.shift_str = '0; bus.shift_amnt = '0; bus.rotate = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_shifted", bus.shifted_str, 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);

    // logical
    send(32'hD6975971, 5'd4, SHIFT_LOGICAL, 32'h69759710);
    wait_latency("latency_first");
    send(32'hD6975971, 5'd2, SHIFT_LOGICAL, 32'h5A5D65C4);
    // rotate
    send(32'hD6975971, 5'd4,  SHIFT_ROTATE, 32'h6975971D);
    send(32'hD6975971, 5'd31, SHIFT_ROTATE, 32'hEB4BACB8);
    send(32'hD6975971, 5'd0,  SHIFT_ROTATE, 32'hD6975971);
    send(32'hD6975971, 5'd0,  SHIFT_LOGICAL, 32'hD6975971);
    // edges
    send(32'h00000001, 5'd31, SHIFT_LOGICAL, 32'h80000000);
    send(32'h80000000, 5'd1,  SHIFT_ROTATE,  32'h00000001);
    send(32'hFFFFFFFF, 5'd16, SHIFT_LOGICAL, 32'hFFFF0000);
    drain("drain_directed");

    // back-to-back
    base = out_cyc.size();
    for (int i = 0; i < 10; i++) send_rand(5'(i), 1'($urandom_range(0, 1)));
    drain("drain_b2b");
    ok = (out_cyc.size() == base + 10) ? 1 : 0;
    for (int j = base + 1; j < out_cyc.size(); j++)
      if (out_cyc[j] != out_cyc[j-1] + 1) ok = 0;
    check("b2b_consecutive", ok, 1);

    // backpressure: fill with consumer stalled
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom; wa[i] = 5'($urandom_range(0, 31)); wr[i] = 1'($urandom_range(0, 1));
    end
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.shift_str = wd[acc]; bus.shift_amnt = wa[acc]; bus.rotate = wr[acc];
      #1;
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back('{valid: 1'b1, data: ref_shift(wd[acc], int'(wa[acc]), wr[acc]),
                          amnt: wa[acc], rot: wr[acc]});
        acc++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("bp_accepted", acc, 5);
    check("bp_in_ready", 32'(bus.in_ready), 0);
    check("bp_out_valid", 32'(bus.out_valid), 1);
    hold = bus.shifted_str;
    repeat (3) @(negedge clk);
    #2;
    check("bp_hold", bus.shifted_str, hold);
    check("bp_first", bus.shifted_str, exp_q[0].data);
    rr_mode = 1'b1;
    for (int i = acc; i < 8; i++) send(wd[i], wa[i], wr[i], ref_shift(wd[i], int'(wa[i]), wr[i]));
    for (int i = 0; i < 20; i++) send_rand(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    drain("drain_bp");
    rr_mode = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b1;

    // reset with 3 words in flight
    for (int i = 0; i < 3; i++) send_rand(5'(i + 3), 1'(i));
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    base = out_cyc.size();
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    check("mid_rst_shifted", bus.shifted_str, 0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 1);
    repeat (10) @(negedge clk);
    check("mid_rst_no_stale", out_cyc.size() - base, 0);
    send(32'h0000F00F, 5'd8, SHIFT_ROTATE, 32'h00F00F00);
    wait_latency("latency_after_rst");
    drain("drain_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
